// File: rtl/hxd32_pkg.sv
// Shared hxd32 core parameters used by the register-file debug initiator.
package hxd32_pkg;

  localparam int XLEN   = 32;
  localparam int GPR_AW = 5;

  localparam logic [GPR_AW-1:0] GPR_LAST = 5'd31;

endpackage

// File: rtl/regfile_dbg.sv
// Debug-side initiator for the hxd32 register file.
// Halts the core, performs one GPR read/write or a full x0..x31 dump through
// the regfile ports, and returns each result on a valid/ready channel.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | ready for a host request, core running
// HALT   | halt_req raised, waiting for the core to report it is stalled
// ACCESS | one cycle on the regfile ports (write pulse or read sample)
// RESP   | response held on rsp_*; dumps loop back to ACCESS for next GPR
module regfile_dbg
  import hxd32_pkg::GPR_AW, hxd32_pkg::GPR_LAST;
#(
  parameter int XLEN = hxd32_pkg::XLEN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wr_i,
  input  logic              req_dump_i,
  input  logic [GPR_AW-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [GPR_AW-1:0] rsp_addr_o,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              rsp_last_o,
  output logic              halt_req_o,
  input  logic              halt_ack_i,
  output logic              rf_wr_en_o,
  output logic [GPR_AW-1:0] rf_wr_addr_o,
  output logic [XLEN-1:0]   rf_wr_data_o,
  output logic [GPR_AW-1:0] rf_rd_addr_o,
  input  logic [XLEN-1:0]   rf_rd_data_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HALT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              mode_wr;
  logic              mode_dump;
  logic [GPR_AW-1:0] cur_addr;
  logic [XLEN-1:0]   wdata;
  logic              more_beats;

  // A dump keeps going until the beat for x31 has been handed off.
  assign more_beats = mode_dump && (cur_addr != GPR_LAST);

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs; no input reaches an output here.
  always_comb begin
    state_nxt    = state;
    req_ready_o  = 1'b0;
    halt_req_o   = 1'b1;
    rsp_valid_o  = 1'b0;
    rf_rd_addr_o = '0;
    rf_wr_en_o   = 1'b0;
    rf_wr_addr_o = '0;
    rf_wr_data_o = '0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        halt_req_o  = 1'b0;
        if (req_valid_i) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        if (halt_ack_i) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        rf_rd_addr_o = cur_addr;
        // x0 is hardwired; skip the write pulse rather than rely on the regfile.
        if (mode_wr && (cur_addr != '0)) begin
          rf_wr_en_o   = 1'b1;
          rf_wr_addr_o = cur_addr;
          rf_wr_data_o = wdata;
        end
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_nxt = more_beats ? ACCESS : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, dump address counter and registered response fields.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_wr    <= 1'b0;
      mode_dump  <= 1'b0;
      cur_addr   <= '0;
      wdata      <= '0;
      rsp_addr_o <= '0;
      rsp_data_o <= '0;
      rsp_last_o <= 1'b0;
    end else begin
      if ((state == IDLE) && req_valid_i) begin
        mode_dump <= req_dump_i;
        mode_wr   <= req_wr_i && !req_dump_i;
        cur_addr  <= req_dump_i ? '0 : req_addr_i;
        wdata     <= req_data_i;
      end
      if (state == ACCESS) begin
        rsp_addr_o <= cur_addr;
        rsp_last_o <= !mode_dump || (cur_addr == GPR_LAST);
        if (mode_wr) begin
          rsp_data_o <= (cur_addr == '0) ? '0 : wdata;
        end else begin
          rsp_data_o <= rf_rd_data_i;
        end
      end
      if ((state == RESP) && rsp_ready_i && more_beats) begin
        cur_addr <= cur_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_dbg.sv
// Self-checking bench for regfile_dbg: behavioural regfile, transaction-level
// reference model of the GPR contents, directed table plus random traffic.
module tb_regfile_dbg;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic        wr;
    logic        dump;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_last;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic        req_dump;
  logic [4:0]  req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        halt_req;
  logic        halt_ack;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;

  int checks = 0;
  int errors = 0;

  // Behavioural hxd32 register file (x0 hardwired to zero).
  logic [31:0] mem [32] = '{default: '0};
  int wr_pulses  = 0;
  int wr0_pulses = 0;

  // Reference model: GPR contents as the host should see them.
  logic [31:0] ref_rf [32];
  int          exp_wr = 0;

  regfile_dbg dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_wr_i     (req_wr),
    .req_dump_i   (req_dump),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_addr_o   (rsp_addr),
    .rsp_data_o   (rsp_data),
    .rsp_last_o   (rsp_last),
    .halt_req_o   (halt_req),
    .halt_ack_i   (halt_ack),
    .rf_wr_en_o   (rf_wr_en),
    .rf_wr_addr_o (rf_wr_addr),
    .rf_wr_data_o (rf_wr_data),
    .rf_rd_addr_o (rf_rd_addr),
    .rf_rd_data_i (rf_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_rd_data = (rf_rd_addr == 5'd0) ? 32'd0 : mem[rf_rd_addr];

  always @(posedge clk) begin
    if (rf_wr_en) begin
      wr_pulses <= wr_pulses + 1;
      if (rf_wr_addr == 5'd0) wr0_pulses <= wr0_pulses + 1;
      else mem[rf_wr_addr] <= rf_wr_data;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_ctrl"},
        {44'd0, req_ready, rsp_valid, rsp_last, halt_req, rf_wr_en, rf_wr_addr, rf_rd_addr, rsp_addr},
        {44'd0, 1'b1, 19'd0});
    chk({name, "_data"}, {rsp_data, rf_wr_data}, 64'd0);
  endtask

  // Expected beats for one request, computed from GPR contents; applies writes.
  task automatic model_req(input logic wr, input logic dump, input logic [4:0] addr,
                           input logic [31:0] data, output beat_t exp[$]);
    exp = {};
    if (dump) begin
      for (int i = 0; i < 32; i++) exp.push_back('{5'(i), ref_rf[i], (i == 31)});
    end else if (wr) begin
      exp.push_back('{addr, (addr == 5'd0) ? 32'd0 : data, 1'b1});
      if (addr != 5'd0) begin
        ref_rf[addr] = data;
        exp_wr++;
      end
    end else begin
      exp.push_back('{addr, ref_rf[addr], 1'b1});
    end
  endtask

  task automatic expect_beats(input string name, input beat_t exp[$], input beat_t got[$]);
    chk({name, "_count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk({name, "_beat"}, 64'(got[i]), 64'(exp[i]));
  endtask

  // Issue one request and collect its responses.
  // rmode: 0 = rsp_ready always 1, 1 = toggling, 2 = random ready and halt_ack.
  task automatic run_req(input logic wr, input logic dump, input logic [4:0] addr,
                         input logic [31:0] data, input int rmode, output beat_t got[$]);
    int    cyc;
    bit    stalled;
    bit    done;
    beat_t held;
    got = {};
    held = '0;
    req_valid = 1'b1; req_wr = wr; req_dump = dump; req_addr = addr; req_data = data;
    cyc = 0;
    while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
    if (!req_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_wr = 1'($urandom); req_dump = 1'($urandom);
    req_addr = 5'($urandom); req_data = $urandom;
    stalled = 1'b0; done = 1'b0; cyc = 0;
    while (!done) begin
      if (cyc > 1000) begin
        chk("rsp_timeout", 64'd0, 64'd1);
        done = 1'b1;
      end else begin
        if (rmode == 2) halt_ack = 1'($urandom_range(0, 1));
        if (stalled) chk("rsp_hold", {25'd0, rsp_valid, rsp_addr, rsp_data, rsp_last}, {25'd0, 1'b1, held});
        if (rmode == 0) rsp_ready = 1'b1;
        else if (rmode == 1) rsp_ready = ~rsp_ready;
        else rsp_ready = 1'($urandom_range(0, 1));
        if (rsp_valid) begin
          held = '{rsp_addr, rsp_data, rsp_last};
          if (rsp_ready) begin
            got.push_back(held);
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
          end
        end
        @(negedge clk);
        cyc++;
        if (got.size() > 0 && got[$].last) done = 1'b1;
      end
    end
    rsp_ready = 1'b0;
    halt_ack = 1'b1;
    chk("idle_after_last", {61'd0, req_ready, halt_req, rsp_valid}, {61'd0, 3'b100});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs [9];
    beat_t got[$];
    beat_t exp[$];
    int    cyc;
    logic  rwr;
    logic  rdump;
    logic [4:0]  raddr;
    logic [31:0] rdata;

    vecs[0] = '{1'b0, 1'b0, 5'd20, 32'h0,         32'd36,        1'b1};
    vecs[1] = '{1'b1, 1'b0, 5'd0,  32'h1234_5678, 32'd0,         1'b1};
    vecs[2] = '{1'b0, 1'b0, 5'd0,  32'h0,         32'd0,         1'b1};
    vecs[3] = '{1'b0, 1'b0, 5'd31, 32'h0,         32'd47,        1'b1};
    vecs[4] = '{1'b1, 1'b0, 5'd31, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 5'd31, 32'h0,         32'hCAFE_F00D, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 5'd31, 32'd47,        32'd47,        1'b1};
    vecs[7] = '{1'b0, 1'b0, 5'd1,  32'h0,         32'd17,        1'b1};
    vecs[8] = '{1'b0, 1'b0, 5'd5,  32'h0,         32'd21,        1'b1};

    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_dump = 1'b0;
    req_addr = 5'd0; req_data = 32'd0; rsp_ready = 1'b0; halt_ack = 1'b1;

    // Reset state
    @(negedge clk); @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Write x5 = DEADBEEF with exact latency
    req_valid = 1'b1; req_wr = 1'b1; req_dump = 1'b0; req_addr = 5'd5; req_data = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid = 1'b0; req_data = 32'd0; req_addr = 5'd0;
    chk("w5_halt", {61'd0, halt_req, rf_wr_en, req_ready}, {61'd0, 3'b100});
    @(negedge clk);
    chk("w5_pulse", {58'd0, rf_wr_en, rf_wr_addr}, {58'd0, 1'b1, 5'd5});
    chk("w5_pulse_data", {32'd0, rf_wr_data}, {32'd0, 32'hDEAD_BEEF});
    chk("w5_no_rsp_yet", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    chk("w5_rsp", {56'd0, rsp_valid, rsp_last, rf_wr_en, rsp_addr}, {56'd0, 3'b110, 5'd5});
    chk("w5_rsp_data", {32'd0, rsp_data}, {32'd0, 32'hDEAD_BEEF});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("w5_idle", {62'd0, halt_req, req_ready}, {62'd0, 2'b01});
    chk("w5_rs1_read", {32'd0, mem[5]}, {32'd0, 32'hDEAD_BEEF});
    model_req(1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, exp);

    // Preload xi = i+16
    for (int i = 1; i < 32; i++) begin
      run_req(1'b1, 1'b0, 5'(i), 32'(i + 16), 0, got);
      model_req(1'b1, 1'b0, 5'(i), 32'(i + 16), exp);
      expect_beats("preload", exp, got);
    end

    // Directed table of single accesses
    for (int i = 0; i < 9; i++) begin
      run_req(vecs[i].wr, vecs[i].dump, vecs[i].addr, vecs[i].data, 0, got);
      model_req(vecs[i].wr, vecs[i].dump, vecs[i].addr, vecs[i].data, exp);
      chk("vec_count", 64'(got.size()), 64'd1);
      if (got.size() > 0)
        chk("vec_beat", 64'(got[0]), 64'({vecs[i].addr, vecs[i].exp_data, vecs[i].exp_last}));
    end
    chk("x0_no_pulse", 64'(wr0_pulses), 64'd0);

    // Dump with toggling rsp_ready; wr/addr fields must be ignored
    run_req(1'b1, 1'b1, 5'd9, 32'hFFFF_FFFF, 1, got);
    model_req(1'b1, 1'b1, 5'd9, 32'hFFFF_FFFF, exp);
    expect_beats("dump_toggle", exp, got);
    if (got.size() == 32) chk("dump_x31", {32'd0, got[31].data}, {32'd0, 32'd47});

    // halt_ack held low: no regfile activity until it rises
    halt_ack = 1'b0;
    req_valid = 1'b1; req_wr = 1'b1; req_dump = 1'b0; req_addr = 5'd9; req_data = 32'hAAAA_5555;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_hold", {52'd0, halt_req, rf_wr_en, rsp_valid, req_ready, rf_rd_addr, 3'd0},
          {52'd0, 4'b1000, 5'd0, 3'd0});
      @(negedge clk);
    end
    halt_ack = 1'b1;
    @(negedge clk);
    chk("stall_access", {58'd0, rf_wr_en, rf_wr_addr}, {58'd0, 1'b1, 5'd9});
    @(negedge clk);
    chk("stall_rsp", {31'd0, rsp_valid, rsp_data}, {31'd0, 1'b1, 32'hAAAA_5555});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("stall_idle", {63'd0, halt_req}, 64'd0);
    model_req(1'b1, 1'b0, 5'd9, 32'hAAAA_5555, exp);

    // Reset during a dump at x12
    req_valid = 1'b1; req_wr = 1'b0; req_dump = 1'b1; req_addr = 5'd0; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!(halt_req && rf_rd_addr == 5'd12) && cyc < 200) begin @(negedge clk); cyc++; end
    if (cyc >= 200) chk("dump12_timeout", 64'd0, 64'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", {62'd0, req_ready, halt_req}, {62'd0, 2'b10});
    run_req(1'b0, 1'b0, 5'd3, 32'd0, 0, got);
    model_req(1'b0, 1'b0, 5'd3, 32'd0, exp);
    expect_beats("read_x3", exp, got);
    if (got.size() > 0) chk("read_x3_const", {32'd0, got[0].data}, 64'd19);

    // Random traffic against the model
    for (int n = 0; n < 40; n++) begin
      rdump = ($urandom_range(0, 7) == 0);
      rwr   = 1'($urandom);
      raddr = 5'($urandom);
      rdata = $urandom;
      if ($urandom_range(0, 5) == 0) raddr = 5'd0;
      run_req(rwr, rdump, raddr, rdata, 2, got);
      model_req(rwr, rdump, raddr, rdata, exp);
      expect_beats("random", exp, got);
    end

    // Final regfile contents and write pulse accounting
    @(negedge clk);
    for (int i = 0; i < 32; i++)
      chk("final_gpr", {32'd0, (i == 0) ? 32'd0 : mem[i]}, {32'd0, ref_rf[i]});
    chk("wr_pulse_total", 64'(wr_pulses), 64'(exp_wr));
    chk("x0_pulse_total", 64'(wr0_pulses), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dbg.md
Name: regfile_dbg

Overview:
- Debug-side initiator for the hxd32 register file. It drives the regfile write port (rd_wr_*) and one read port (rs*_rd_*) on behalf of a debug host.
- The host issues single GPR read/write requests, or a full 32-register dump, over a valid/ready request channel. Results return on a valid/ready response channel.
- The core is halted via a halt_req/halt_ack handshake around every access, so debug writes never collide with core writeback.

Parameters:
- XLEN, 32, register data width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  host request valid.
- req_ready_o  out  1  block can accept a request.
- req_wr_i  in  1  1 = write, 0 = read.
- req_dump_i  in  1  1 = dump x0..x31; overrides req_wr_i and req_addr_i.
- req_addr_i  in  5  GPR index.
- req_data_i  in  XLEN  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  host accepts response.
- rsp_addr_o  out  5  GPR index of this response.
- rsp_data_o  out  XLEN  read data, or written data for writes.
- rsp_last_o  out  1  final response of the request.
- halt_req_o  out  1  request core stall.
- halt_ack_i  in  1  core is stalled and its writeback is idle.
- rf_wr_en_o  out  1  regfile write enable.
- rf_wr_addr_o  out  5  regfile write address.
- rf_wr_data_o  out  XLEN  regfile write data.
- rf_rd_addr_o  out  5  regfile read address.
- rf_rd_data_i  in  XLEN  regfile read data; combinational from rf_rd_addr_o, same cycle.

Behaviour:
- Reset (async, rst_i=1):
  - State goes to IDLE.
  - req_ready_o=1; all other outputs are 0, including rf_wr_en_o, rf_rd_addr_o and halt_req_o.
  - Internal addr/data/mode registers are cleared.
  - Reset mid-operation aborts immediately; no partial write pulse survives the reset edge.
- All outputs are registered or decoded from state only; there is no combinational path from input to output.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o, latch the mode: dump if req_dump_i, else wr/rd.
  - Latch cur_addr = req_dump_i ? 0 : req_addr_i, and latch req_data_i.
  - Next state HALT.
- HALT:
  - halt_req_o=1, held until the block returns to IDLE.
  - Stay in HALT until halt_ack_i=1 is sampled, then go to ACCESS.
- ACCESS (exactly one cycle):
  - rf_rd_addr_o=cur_addr.
  - Write to a nonzero address: rf_wr_en_o=1, rf_wr_addr_o=cur_addr, rf_wr_data_o=latched data, for exactly one cycle. rsp_data register ← latched data.
  - Write to x0: no write pulse; rsp_data register ← 0.
  - Read or dump: rsp_data register ← rf_rd_data_i sampled at the end of the cycle.
  - rsp_addr register ← cur_addr; rsp_last register ← (not dump) | (cur_addr==31).
  - Next state RESP.
- RESP:
  - rsp_valid_o=1; rsp_* held stable until rsp_ready_i.
  - On handshake, if dump and cur_addr≠31: cur_addr += 1, go to ACCESS.
  - Otherwise go to IDLE; halt_req_o deasserts in that cycle.
- halt_ack_i is ignored after entering ACCESS; the core must stay stalled while halt_req_o=1.
- Latency with halt_ack_i=1 and rsp_ready_i=1:
  - Accept at cycle N, HALT at N+1, ACCESS at N+2, rsp_valid_o at N+3.
  - A dump produces 32 responses, one every 2 cycles; 64 cycles from the first ACCESS to the last handshake.
- rf_rd_addr_o returns to 0 in IDLE and HALT.
- cur_addr never wraps. The dump terminates at 31, and rsp_last_o=1 only on that beat.
- req_valid_i during a busy state is not accepted (req_ready_o=0); the host holds its request.

Decomposition:
- XLEN and the 5-bit GPR index width belong in the shared hxd32 package.
- The FSM state enum (IDLE, HALT, ACCESS, RESP) is declared locally.
- No sub-module: single FSM plus address counter, roughly 150–200 lines.

Test Plan:
- Write x5 = 32'hDEAD_BEEF, halt_ack_i tied 1:
  - rf_wr_en_o pulses one cycle at N+2 with addr 5.
  - rsp_valid_o at N+3 with data DEAD_BEEF and rsp_last_o=1.
  - Regfile rs1 read of x5 returns DEAD_BEEF.
- Preload xi = i+16 through the write port, then single read of x20:
  - Response rsp_addr_o=20, rsp_data_o=36, halt_req_o low the cycle after the handshake.
- Dump with rsp_ready_i toggling 1/0 every cycle:
  - 32 responses, addr 0..31, data 0 (x0) then i+16.
  - rsp_last_o only on addr 31; no duplicate or dropped beat; rsp_* stable while stalled.
- Write x0 = 32'h1234_5678:
  - No rf_wr_en_o pulse; rsp_data_o=0; a subsequent read of x0 returns 0.
- halt_ack_i held 0 for 10 cycles:
  - Block stays in HALT with halt_req_o=1 and no rf activity.
  - Access completes 2 cycles after halt_ack_i rises.
- Assert rst_i during a dump at addr 12:
  - All outputs 0 asynchronously, req_ready_o=1 after release.
  - A new read of x3 returns 19.
